// File: rtl/latch_checker_pkg.sv
// latch_checker_pkg: shared types and constants for the latch checker.
//   state_e   - checker FSM encoding (INIT=0, TRANSP=1, HOLD=2, 3 unused)
//   SettleW   - width of the settle counter, covers SETTLE values 0..15
package latch_checker_pkg;

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StTransp = 2'd1,
        StHold   = 2'd2,
        StUnused = 2'd3
    } state_e;

    localparam int unsigned SettleW   = 4;
    localparam int unsigned SettleMax = (1 << SettleW) - 1;

endpackage

// File: rtl/latch_checker_if.sv
// latch_checker_if: observed latch pins plus checker results.
//   d, enable, q   - latch data, enable and output as seen by the checker
//   err            - one-cycle pulse per failing check
//   err_count      - saturating mismatch count
//   check_count    - saturating checked-cycle count
//   hold_val       - value captured at the last enable fall
//   state          - checker FSM state
// master: drives the latch pins and reads results; slave: the checker.
interface latch_checker_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             d;
    logic             enable;
    logic             q;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] check_count;
    logic             hold_val;
    logic [1:0]       state;

    modport master (
        output d, enable, q,
        input  err, err_count, check_count, hold_val, state
    );

    modport slave (
        input  d, enable, q,
        output err, err_count, check_count, hold_val, state
    );
endinterface

// File: rtl/latch_checker_sat_counter.sv
// sat_counter: W-bit up counter that stops at all-ones instead of wrapping.
//   clk    - clock, rising edge
//   reset  - asynchronous active-high clear
//   inc    - count one on this edge
//   count  - current value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/latch_checker.sv
// latch_checker: clocked observer for a level-sensitive D latch.
// Samples d/enable/q, checks that q follows d while enable is high (after a
// SETTLE-cycle grace period) and that q holds the value captured at the enable
// fall while enable is low.
//   clk    - sampling clock, rising edge
//   reset  - asynchronous active-high clear of all state
//   bus    - slave side of latch_checker_if (latch pins in, results out)
// Parameters: CNT_W counter width, SETTLE grace cycles (0..15).
module latch_checker
    import latch_checker_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SETTLE = 1
) (
    input logic            clk,
    input logic            reset,
    latch_checker_if.slave bus
);

    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE);

    // Input stage: one register on every pin, one extra on d and enable so
    // edges can be detected.
    logic d_r, en_r, q_r, d_p, en_p;

    state_e             state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic               hold_q, hold_d;
    logic               err_q, err_d;
    logic               do_check;
    logic               exp_q;

    logic [CNT_W-1:0]   err_cnt;
    logic [CNT_W-1:0]   chk_cnt;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        do_check = 1'b0;
        exp_q    = d_r;

        case (state_q)
            StInit: begin
                // No hold reference exists until enable has been seen high.
                if (en_r) begin
                    state_d  = StTransp;
                    settle_d = SettleLoad;
                end
            end
            StTransp: begin
                if (!en_r && en_p) begin
                    // d_p is the last d sampled while enable was high.
                    hold_d  = d_p;
                    state_d = StHold;
                end else if (d_r != d_p) begin
                    settle_d = SettleLoad;
                    // With no grace period the change cycle itself is checked.
                    do_check = (SETTLE == 0);
                end else if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    do_check = 1'b1;
                end
            end
            StHold: begin
                if (en_r) begin
                    state_d  = StTransp;
                    settle_d = SettleLoad;
                end else begin
                    do_check = 1'b1;
                    exp_q    = hold_q;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        err_d = do_check && (q_r != exp_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_r      <= 1'b0;
            en_r     <= 1'b0;
            q_r      <= 1'b0;
            d_p      <= 1'b0;
            en_p     <= 1'b0;
            state_q  <= StInit;
            settle_q <= '0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            d_r      <= bus.d;
            en_r     <= bus.enable;
            q_r      <= bus.q;
            d_p      <= d_r;
            en_p     <= en_r;
            state_q  <= state_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_d),
        .count (err_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_chk_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (do_check),
        .count (chk_cnt)
    );

    assign bus.err         = err_q;
    assign bus.err_count   = err_cnt;
    assign bus.check_count = chk_cnt;
    assign bus.hold_val    = hold_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_latch_checker.sv
// tb_latch_checker: drives two checkers (CNT_W=8/SETTLE=1 and CNT_W=4/SETTLE=0)
// from one behavioural latch with optional output lag and bit flips, and
// compares every output each cycle against a sample-level reference model.
module tb_latch_checker;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    latch_checker_if #(.CNT_W(8)) bus0 ();
    latch_checker_if #(.CNT_W(4)) bus1 ();

    latch_checker #(
        .CNT_W (8),
        .SETTLE(1)
    ) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    latch_checker #(
        .CNT_W (4),
        .SETTLE(0)
    ) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int settle_cfg [2] = '{1, 0};
    int cnt_max    [2] = '{255, 15};

    // Reference model state, one slot per checker instance.
    bit m_seen    [2];
    bit m_prev_en [2];
    bit m_prev_d  [2];
    bit m_held    [2];
    bit m_err     [2];
    int m_age     [2];
    int m_checks  [2];
    int m_errs    [2];

    // Behavioural latch plus a short history of its output for lag injection.
    bit lat;
    bit hist [4];

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int exp_state(input int i);
        if (!m_seen[i]) return 0;
        if (m_prev_en[i]) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seen[i]    = 1'b0;
            m_prev_en[i] = 1'b0;
            m_prev_d[i]  = 1'b0;
            m_held[i]    = 1'b0;
            m_err[i]     = 1'b0;
            m_age[i]     = 0;
            m_checks[i]  = 0;
            m_errs[i]    = 0;
        end
    endtask

    // One sample of (d, enable, q): decide whether this sample is checked and
    // against what, in terms of enable edges and cycles since the last event.
    task automatic model_step(input int i, input bit dv, input bit ev, input bit qv);
        bit chk;
        bit want;
        chk      = 1'b0;
        want     = dv;
        m_err[i] = 1'b0;
        if (!m_seen[i]) begin
            if (ev) begin
                m_seen[i] = 1'b1;
                m_age[i]  = 0;
            end
        end else if (ev && !m_prev_en[i]) begin
            m_age[i] = 0;
        end else if (!ev && m_prev_en[i]) begin
            m_held[i] = m_prev_d[i];
        end else if (!ev) begin
            chk  = 1'b1;
            want = m_held[i];
        end else if (dv != m_prev_d[i]) begin
            m_age[i] = 0;
            chk      = (settle_cfg[i] == 0);
        end else begin
            if (m_age[i] < 1000) m_age[i]++;
            chk = (m_age[i] > settle_cfg[i]);
        end
        if (chk) begin
            if (m_checks[i] < cnt_max[i]) m_checks[i]++;
            if (qv != want) begin
                m_err[i] = 1'b1;
                if (m_errs[i] < cnt_max[i]) m_errs[i]++;
            end
        end
        m_prev_en[i] = ev;
        m_prev_d[i]  = dv;
    endtask

    task automatic compare_all();
        check("err0",         int'(bus0.err),         int'(m_err[0]));
        check("err_count0",   int'(bus0.err_count),   m_errs[0]);
        check("check_count0", int'(bus0.check_count), m_checks[0]);
        check("hold_val0",    int'(bus0.hold_val),    int'(m_held[0]));
        check("state0",       int'(bus0.state),       exp_state(0));
        check("err1",         int'(bus1.err),         int'(m_err[1]));
        check("err_count1",   int'(bus1.err_count),   m_errs[1]);
        check("check_count1", int'(bus1.check_count), m_checks[1]);
        check("hold_val1",    int'(bus1.hold_val),    int'(m_held[1]));
        check("state1",       int'(bus1.state),       exp_state(1));
    endtask

    // Drive one sample, let the checkers take it, compare their outputs
    // (which reflect the previous sample), then advance the model.
    task automatic cycle(input bit dv, input bit ev, input bit qv);
        bus0.d = dv; bus0.enable = ev; bus0.q = qv;
        bus1.d = dv; bus1.enable = ev; bus1.q = qv;
        @(posedge clk);
        #1;
        compare_all();
        model_step(0, dv, ev, qv);
        model_step(1, dv, ev, qv);
    endtask

    task automatic apply(input bit dv, input bit ev, input int lag, input bit flip);
        bit qv;
        if (ev) lat = dv;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = lat;
        qv = hist[lag] ^ flip;
        cycle(dv, ev, qv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    bit dpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int  e0;
        int  lag_cur;
        bit  en_cur;
        bit  d_cur;
        bit  flip;

        lat = 1'b0;
        for (int k = 0; k < 4; k++) hist[k] = 1'b0;
        bus0.d = 1'b0; bus0.enable = 1'b0; bus0.q = 1'b0;
        bus1.d = 1'b0; bus1.enable = 1'b0; bus1.q = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Idle with enable low: never leaves INIT, nothing checked.
        repeat (10) cycle(1'b1, 1'b0, 1'b0);

        // Correct latch, enable toggling every 5 cycles, d pattern every 20.
        for (int c = 0; c < 80; c++) begin
            apply(dpat[(c / 20) % 4], ((c / 5) % 2) == 0, 0, 1'b0);
        end

        // Hold violation: three cycles of q=0 after enable falls with d=1.
        e0 = int'(bus0.err_count);
        repeat (6) apply(1'b1, 1'b1, 0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b1);
        check("hold_viol_errs", int'(bus0.err_count) - e0, 3);

        // Transparency lag of one cycle is masked by SETTLE=1.
        repeat (6) apply(1'b0, 1'b1, 1, 1'b0);
        e0 = int'(bus0.err_count);
        repeat (8) apply(1'b1, 1'b1, 1, 1'b0);
        check("lag1_errs", int'(bus0.err_count) - e0, 0);

        // Three-cycle lag: exactly one unmasked mismatch per d change.
        repeat (8) apply(1'b0, 1'b1, 3, 1'b0);
        e0 = int'(bus0.err_count);
        repeat (8) apply(1'b1, 1'b1, 3, 1'b0);
        check("lag3_errs", int'(bus0.err_count) - e0, 1);

        // Randomised traffic with occasional faults, lag changes and resets.
        lag_cur = 0;
        en_cur  = 1'b1;
        d_cur   = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1000 || n == 2000) do_reset();
            if ($urandom_range(0, 7) == 0) en_cur = ~en_cur;
            if ($urandom_range(0, 99) == 0) lag_cur = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) d_cur = ~d_cur;
            flip = ($urandom_range(0, 15) == 0);
            apply(d_cur, en_cur, lag_cur, flip);
        end

        // Reset in the middle of a failing hold period, then resume.
        repeat (5) apply(1'b1, 1'b1, 0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b0);
        repeat (6) apply(1'b1, 1'b0, 0, 1'b1);
        do_reset();
        repeat (4) apply(1'b0, 1'b0, 0, 1'b0);
        repeat (6) apply(1'b0, 1'b1, 0, 1'b0);
        repeat (3) apply(1'b1, 1'b1, 0, 1'b1);
        repeat (4) apply(1'b1, 1'b0, 0, 1'b0);
        repeat (2) apply(1'b1, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
